// File: rtl/horner_pass_sequencer_pkg.sv
// Shared definitions for the Horner pass sequencer: FSM state encoding,
// coefficient-select width and order limits.
package horner_pass_sequencer_pkg;

    localparam int SEL_W     = 4;   // width of coeff_sel / cfg_addr
    localparam int FP_W_DEF  = 32;  // default smc_float word width
    localparam int ORDER_MAX = 15;  // largest order addressable by SEL_W bits

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/horner_coeff_bank.sv
// Coefficient register file for the Horner sequencer.
// Optional feature macro: COEFF_BANK_SWAP_EN
//   undefined: single bank, writes accepted only while the sequencer is idle.
//   defined:   live + shadow banks; writes always land in the shadow bank and a
//              swap request exchanges the banks at the next safe point (idle or
//              load), so a sample in flight never sees a coefficient change.
module horner_coeff_bank
    import horner_pass_sequencer_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int FP_W  = FP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
`ifdef COEFF_BANK_SWAP_EN
    input  logic             swap_ok_i,
    input  logic             cfg_swap_i,
`else
    input  logic             busy_i,
`endif
    input  logic             cfg_we_i,
    input  logic [SEL_W-1:0] cfg_addr_i,
    input  logic [FP_W-1:0]  cfg_wdata_i,
    input  logic [SEL_W-1:0] rd_sel_i,
    output logic [FP_W-1:0]  rd_data_o,
    output logic             cfg_rdy_o
);

    // Live (datapath-visible) word of every entry, gathered for the read mux.
    logic [FP_W-1:0] live_w [DEPTH];

`ifdef COEFF_BANK_SWAP_EN
    logic swap_pend_q;
    logic swap_now;

    // A request made this cycle counts too, so an idle swap takes effect at once.
    assign swap_now  = (swap_pend_q | cfg_swap_i) & swap_ok_i;
    assign cfg_rdy_o = 1'b1;

    // Remember a swap request until the sequencer reaches a sample boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_pend_q <= 1'b0;
        end else if (swap_now) begin
            swap_pend_q <= 1'b0;
        end else if (cfg_swap_i) begin
            swap_pend_q <= 1'b1;
        end
    end
`else
    assign cfg_rdy_o = ~busy_i;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic wr_hit;
`ifdef COEFF_BANK_SWAP_EN
            logic [FP_W-1:0] live_q;
            logic [FP_W-1:0] shadow_q;
            logic [FP_W-1:0] shadow_w;

            assign wr_hit   = cfg_we_i && (cfg_addr_i == SEL_W'(gi));
            // A write in the same cycle as the swap is folded in first so it goes live.
            assign shadow_w = wr_hit ? cfg_wdata_i : shadow_q;

            // Shadow takes writes; on swap the two banks exchange contents.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    live_q   <= '0;
                    shadow_q <= '0;
                end else if (swap_now) begin
                    live_q   <= shadow_w;
                    shadow_q <= live_q;
                end else begin
                    shadow_q <= shadow_w;
                end
            end
`else
            logic [FP_W-1:0] live_q;

            assign wr_hit = cfg_we_i && !busy_i && (cfg_addr_i == SEL_W'(gi));

            // Single bank: capture the write only while no sample is in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    live_q <= '0;
                end else if (wr_hit) begin
                    live_q <= cfg_wdata_i;
                end
            end
`endif
            assign live_w[gi] = live_q;
        end
    endgenerate

    // Combinational read of the registered bank; out-of-range selects read zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_data_o = live_w[i];
            end
        end
    end

endmodule

// File: rtl/horner_pass_sequencer.sv
// Horner pass sequencer: drives the shared multiply/add/delay_sum loop so that
// one sample is evaluated as ORDER+1 multiply-add passes, highest coefficient
// first. One extra sample arriving while busy is parked in a pending slot.
// Optional feature macro: COEFF_BANK_SWAP_EN (adds cfg_swap and a shadow bank).
module horner_pass_sequencer
    import horner_pass_sequencer_pkg::*;
#(
    parameter int ORDER        = 4,
    parameter int FP_W         = FP_W_DEF,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             sample_vld,
    input  logic [FP_W-1:0]  sample_i,
    input  logic             loop_rdy,
    output logic [FP_W-1:0]  x_o,
    output logic             pass_vld,
    output logic [SEL_W-1:0] coeff_sel,
    output logic [FP_W-1:0]  coeff_o,
    output logic             sum_rst,
    output logic             sum_en,
    output logic             srdyo,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_addr,
    input  logic [FP_W-1:0]  cfg_wdata,
`ifdef COEFF_BANK_SWAP_EN
    input  logic             cfg_swap,
`endif
    output logic             cfg_rdy
);

    localparam int                     TMR_W     = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [SEL_W-1:0]       ORDER_SEL = SEL_W'(ORDER);
    localparam logic [TMR_W-1:0]       TMR_LAST  = TMR_W'(WAIT_TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [FP_W-1:0]  x_q, x_d;
    logic [FP_W-1:0]  pend_data_q, pend_data_d;
    logic             pend_full_q, pend_full_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             consume;
    logic             abort;
    logic             bank_rdy;

    // State, counters, held sample, pending slot and sticky flags.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            x_q         <= '0;
            pend_data_q <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            x_q         <= x_d;
            pend_data_q <= pend_data_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic: pass sequencing, timeout abort and pending-slot bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        x_d         = x_q;
        pend_data_d = pend_data_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        consume     = 1'b0;
        abort       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A parked sample is older than anything arriving now.
                if (pend_full_q) begin
                    state_d = ST_LOAD;
                    x_d     = pend_data_q;
                    consume = 1'b1;
                end else if (sample_vld) begin
                    state_d = ST_LOAD;
                    x_d     = sample_i;
                end
            end
            ST_LOAD: begin
                idx_d   = ORDER_SEL;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (loop_rdy) begin
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - SEL_W'(1);
                        state_d = ST_ISSUE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    abort     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                if (pend_full_q) begin
                    state_d = ST_LOAD;
                    x_d     = pend_data_q;
                    consume = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Samples not taken straight from IDLE go to the slot; a slot freed this
        // cycle can take the new one, otherwise the newest sample is lost.
        if (sample_vld && !(state_q == ST_IDLE && !pend_full_q)) begin
            if (!pend_full_q || consume) begin
                pend_data_d = sample_i;
                pend_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            pend_full_d = 1'b0;
        end
    end

    horner_coeff_bank #(
        .DEPTH (ORDER + 1),
        .FP_W  (FP_W)
    ) u_bank (
        .clk         (clk),
        .rst         (GlobalReset),
`ifdef COEFF_BANK_SWAP_EN
        .swap_ok_i   ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
        .cfg_swap_i  (cfg_swap),
`else
        .busy_i      (state_q != ST_IDLE),
`endif
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .rd_sel_i    (coeff_sel),
        .rd_data_o   (coeff_o),
        .cfg_rdy_o   (bank_rdy)
    );

    assign x_o         = x_q;
    assign pass_vld    = (state_q == ST_ISSUE);
    assign coeff_sel   = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? idx_q : '0;
    assign sum_rst     = (state_q == ST_LOAD) || abort;
    assign sum_en      = (state_q == ST_WAIT) && loop_rdy;
    assign srdyo       = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    // Held low while reset is asserted so every output reads zero during reset.
    assign cfg_rdy     = bank_rdy & ~GlobalReset;

endmodule

// File: tb/tb_horner_pass_sequencer.sv
// Directed bench for horner_pass_sequencer (ORDER=2, WAIT_TIMEOUT=64).
// Build with COEFF_BANK_SWAP_EN defined to exercise the shadow-bank path.
module tb_horner_pass_sequencer;

    localparam int ORDER = 2;
    localparam int FP_W  = 32;

    localparam logic [31:0] C1  = 32'h3F80_0000; // 1.0
    localparam logic [31:0] C2  = 32'h4000_0000; // 2.0
    localparam logic [31:0] C3  = 32'h4040_0000; // 3.0
    localparam logic [31:0] C5  = 32'h40A0_0000; // 5.0
    localparam logic [31:0] S_A = 32'h4020_0000;
    localparam logic [31:0] S_B = 32'h3FC0_0000;
    localparam logic [31:0] S_C = 32'h40E0_0000;
    localparam logic [31:0] S_D = 32'h4110_0000;

    logic            clk;
    logic            GlobalReset;
    logic            sample_vld;
    logic [FP_W-1:0] sample_i;
    logic            loop_rdy;
    logic [FP_W-1:0] x_o;
    logic            pass_vld;
    logic [3:0]      coeff_sel;
    logic [FP_W-1:0] coeff_o;
    logic            sum_rst;
    logic            sum_en;
    logic            srdyo;
    logic            busy;
    logic            overrun;
    logic            timeout_err;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [FP_W-1:0] cfg_wdata;
`ifdef COEFF_BANK_SWAP_EN
    logic            cfg_swap;
`endif
    logic            cfg_rdy;

    horner_pass_sequencer #(
        .ORDER        (ORDER),
        .FP_W         (FP_W),
        .WAIT_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .sample_vld  (sample_vld),
        .sample_i    (sample_i),
        .loop_rdy    (loop_rdy),
        .x_o         (x_o),
        .pass_vld    (pass_vld),
        .coeff_sel   (coeff_sel),
        .coeff_o     (coeff_o),
        .sum_rst     (sum_rst),
        .sum_en      (sum_en),
        .srdyo       (srdyo),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
`ifdef COEFF_BANK_SWAP_EN
        .cfg_swap    (cfg_swap),
`endif
        .cfg_rdy     (cfg_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor / loop model state (written only by the monitor process).
    int          cyc = 0;
    int          n_pass = 0, n_sum_en = 0, n_sum_rst = 0, n_srdyo = 0, n_b2b = 0;
    int          last_pass_cyc = 0, last_sumen_cyc = 0, last_sumrst_cyc = 0, last_srdyo_cyc = 0;
    int          cd = 0;
    logic        prev_srdyo = 1'b0;
    logic [3:0]  sel_q [$];
    logic [31:0] coef_q [$];
    logic [31:0] xdone_q [$];
    logic        resp_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Datapath stand-in: answers each pass_vld with loop_rdy three cycles later,
    // and tallies the control strobes seen at each falling edge.
    always begin
        @(posedge clk);
        #1;
        loop_rdy = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) loop_rdy = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (pass_vld) begin
            n_pass++;
            last_pass_cyc = cyc;
            sel_q.push_back(coeff_sel);
            coef_q.push_back(coeff_o);
            if (resp_en) cd = 3;
        end
        if (sum_en) begin
            n_sum_en++;
            last_sumen_cyc = cyc;
        end
        if (sum_rst) begin
            n_sum_rst++;
            last_sumrst_cyc = cyc;
            if (prev_srdyo) n_b2b++;
        end
        if (srdyo) begin
            n_srdyo++;
            last_srdyo_cyc = cyc;
            xdone_q.push_back(x_o);
        end
        prev_srdyo = srdyo;
    end

    task automatic send_sample(input logic [31:0] x);
        @(posedge clk); #1;
        sample_vld = 1'b1;
        sample_i   = x;
        @(posedge clk); #1;
        sample_vld = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, output logic rdy);
        @(posedge clk); #1;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        rdy = cfg_rdy;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

`ifdef COEFF_BANK_SWAP_EN
    task automatic pulse_swap();
        @(posedge clk); #1;
        cfg_swap = 1'b1;
        @(posedge clk); #1;
        cfg_swap = 1'b0;
    endtask
`endif

    task automatic wait_srdyo(input int target, input string tag);
        int k = 0;
        while (n_srdyo < target && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 32'(n_srdyo), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_pass(input int target, input string tag);
        int k = 0;
        while (n_pass < target && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 32'(n_pass >= target), 32'd1);
    endtask

    task automatic run_eval(input logic [31:0] x, input string tag);
        int s0 = n_srdyo;
        int p0 = n_pass;
        send_sample(x);
        wait_srdyo(s0 + 1, {tag, "_srdyo"});
        wait_idle({tag, "_idle"});
        $display("eval %s: x=%h passes=%0d srdyo=%0d", tag, x, n_pass - p0, n_srdyo - s0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   b, p0, e0, r0, s0, b2b0, xb;
        logic rdy;

        GlobalReset = 1'b1;
        sample_vld  = 1'b0;
        sample_i    = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
`ifdef COEFF_BANK_SWAP_EN
        cfg_swap    = 1'b0;
`endif

        // Reset state: every output low.
        repeat (2) @(negedge clk);
        check_eq("rst_ctrl", 32'({pass_vld, sum_rst, sum_en, srdyo, busy, overrun, timeout_err, cfg_rdy}), 32'd0);
        check_eq("rst_x", x_o, 32'd0);
        check_eq("rst_sel", 32'(coeff_sel), 32'd0);
        @(posedge clk); #1;
        GlobalReset = 1'b0;
        @(negedge clk);
        check_eq("idle_cfg_rdy", 32'(cfg_rdy), 32'd1);

        // Load c = {1.0, 2.0, 3.0}.
        cfg_write(4'd0, C1, rdy);
        cfg_write(4'd1, C2, rdy);
        cfg_write(4'd2, C3, rdy);
`ifdef COEFF_BANK_SWAP_EN
        pulse_swap();
`endif

        // 1: one sample, three passes highest coefficient first.
        b  = coef_q.size();
        xb = xdone_q.size();
        p0 = n_pass; e0 = n_sum_en; r0 = n_sum_rst; b2b0 = n_b2b;
        run_eval(S_A, "t1");
        check_eq("t1_passes", 32'(n_pass - p0), 32'd3);
        check_eq("t1_sum_en", 32'(n_sum_en - e0), 32'd3);
        check_eq("t1_sum_rst", 32'(n_sum_rst - r0), 32'd1);
        check_eq("t1_sel0", 32'(sel_q[b]), 32'd2);
        check_eq("t1_sel1", 32'(sel_q[b+1]), 32'd1);
        check_eq("t1_sel2", 32'(sel_q[b+2]), 32'd0);
        check_eq("t1_coef0", coef_q[b], C3);
        check_eq("t1_coef1", coef_q[b+1], C2);
        check_eq("t1_coef2", coef_q[b+2], C1);
        check_eq("t1_srdyo_lat", 32'(last_srdyo_cyc - last_sumen_cyc), 32'd1);
        check_eq("t1_x", xdone_q[xb], S_A);

        // 2: second sample parked, third one overruns.
        s0 = n_srdyo; b2b0 = n_b2b; xb = xdone_q.size();
        send_sample(S_B);
        send_sample(S_C);
        @(posedge clk); #1;
        check_eq("t2_no_overrun", 32'(overrun), 32'd0);
        send_sample(S_D);
        @(posedge clk); #1;
        check_eq("t2_overrun", 32'(overrun), 32'd1);
        wait_srdyo(s0 + 2, "t2_two_srdyo");
        repeat (30) @(posedge clk);
        #1;
        check_eq("t2_only_two", 32'(n_srdyo - s0), 32'd2);
        check_eq("t2_back_to_back", 32'(n_b2b - b2b0), 32'd1);
        check_eq("t2_x_first", xdone_q[xb], S_B);
        check_eq("t2_x_second", xdone_q[xb+1], S_C);
        $display("eval t2: srdyo=%0d overrun=%0d", n_srdyo - s0, overrun);

        // 3: loop_rdy withheld -> timeout after 64 WAIT cycles.
        resp_en = 1'b0;
        s0 = n_srdyo; p0 = n_pass; r0 = n_sum_rst;
        check_eq("t3_no_timeout_yet", 32'(timeout_err), 32'd0);
        send_sample(S_A);
        wait_idle("t3_idle");
        check_eq("t3_timeout_err", 32'(timeout_err), 32'd1);
        check_eq("t3_no_srdyo", 32'(n_srdyo - s0), 32'd0);
        check_eq("t3_one_pass", 32'(n_pass - p0), 32'd1);
        check_eq("t3_abort_rst", 32'(n_sum_rst - r0), 32'd2);
        check_eq("t3_wait_len", 32'(last_sumrst_cyc - last_pass_cyc), 32'd64);
        $display("eval t3: timeout_err=%0d wait=%0d", timeout_err, last_sumrst_cyc - last_pass_cyc);
        resp_en = 1'b1;

`ifndef COEFF_BANK_SWAP_EN
        // 4: writes while busy are refused; writes in IDLE land.
        b = coef_q.size(); p0 = n_pass; s0 = n_srdyo;
        send_sample(S_A);
        wait_pass(p0 + 1, "t4_started");
        cfg_write(4'd0, C5, rdy);
        check_eq("t4_cfg_rdy_busy", 32'(rdy), 32'd0);
        wait_srdyo(s0 + 1, "t4_srdyo");
        wait_idle("t4_idle");
        check_eq("t4_coef0_in_flight", coef_q[b+2], C1);
        b = coef_q.size();
        run_eval(S_B, "t4b");
        check_eq("t4_coef0_unchanged", coef_q[b+2], C1);
        cfg_write(4'd3, S_C, rdy);
        check_eq("t4_cfg_rdy_oob", 32'(rdy), 32'd1);
        cfg_write(4'd0, C5, rdy);
        check_eq("t4_cfg_rdy_idle", 32'(rdy), 32'd1);
        b = coef_q.size();
        run_eval(S_C, "t4c");
        check_eq("t4_coef0_written", coef_q[b+2], C5);
        check_eq("t4_coef2_kept", coef_q[b], C3);
`else
        // 5: shadow write + swap mid-sample takes effect on the next sample only.
        b = coef_q.size(); p0 = n_pass; s0 = n_srdyo;
        send_sample(S_A);
        wait_pass(p0 + 1, "t5_started");
        cfg_write(4'd0, C5, rdy);
        check_eq("t5_cfg_rdy_busy", 32'(rdy), 32'd1);
        pulse_swap();
        wait_srdyo(s0 + 1, "t5_srdyo");
        wait_idle("t5_idle");
        check_eq("t5_coef0_old", coef_q[b+2], C1);
        b = coef_q.size();
        run_eval(S_B, "t5b");
        check_eq("t5_sel0", 32'(sel_q[b+2]), 32'd0);
        check_eq("t5_coef0_new", coef_q[b+2], C5);
`endif

        // 6: reset in WAIT with a parked sample -> outputs zero at once, nothing resumes.
        p0 = n_pass;
        send_sample(S_A);
        send_sample(S_B);
        wait_pass(p0 + 1, "t6_started");
        GlobalReset = 1'b1;
        #1;
        check_eq("t6_rst_ctrl", 32'({pass_vld, sum_rst, sum_en, srdyo, busy, overrun, timeout_err, cfg_rdy}), 32'd0);
        check_eq("t6_rst_sel", 32'(coeff_sel), 32'd0);
        check_eq("t6_rst_x", x_o, 32'd0);
        check_eq("t6_rst_coef", coeff_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        GlobalReset = 1'b0;
        s0 = n_srdyo;
        repeat (30) @(posedge clk);
        #1;
        check_eq("t6_no_srdyo", 32'(n_srdyo - s0), 32'd0);
        check_eq("t6_idle", 32'(busy), 32'd0);
        check_eq("t6_cfg_rdy", 32'(cfg_rdy), 32'd1);
        $display("eval t6: reset in WAIT, srdyo after release=%0d", n_srdyo - s0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
